// File: rtl/div_prog.sv
// Runtime-programmable integer clock divider (ratios 2..2^WIDTH-1) with
// boundary-synchronous reprogramming. Optional 50% odd duty: DIV_PROG_ODD_DUTY50_EN.
module div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             div_ack,
   output logic             div_err,
   output logic [WIDTH-1:0] div_cur,
   output logic             wrap,
   output logic             clk_out
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] pend_val;
   logic             pend_vld;
   logic             pos_q;
   logic             ack_q;
   logic             err_q;

   logic             load_ok;
   logic             load_bad;
   logic             at_wrap;
   logic             boundary;
   logic             apply;
   logic [WIDTH-1:0] div_nxt;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH:0]   half_len;
   logic             pos_nxt;

   // A stopped divider is treated as permanently sitting on a period boundary,
   // so a legal load lands on the very next edge.
   always_comb begin
      load_ok  = div_load && (div_in >= MIN_DIV);
      load_bad = div_load && (div_in <  MIN_DIV);
      at_wrap  = (cnt == div_q - ONE);
      boundary = !enable || at_wrap;
      apply    = boundary && (load_ok || pend_vld);
      div_nxt  = load_ok ? div_in : pend_val;
      cnt_nxt  = boundary ? '0 : cnt + ONE;
      half_len = ({1'b0, div_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
      pos_nxt  = !boundary && ({1'b0, cnt_nxt} >= half_len);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= DEF_DIV;
         cnt      <= '0;
         pend_val <= '0;
         pend_vld <= 1'b0;
         pos_q    <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         ack_q <= apply;
         err_q <= load_bad;
         cnt   <= cnt_nxt;
         pos_q <= pos_nxt;
         if (apply) begin
            div_q    <= div_nxt;
            pend_vld <= 1'b0;
         end else if (load_ok) begin
            pend_val <= div_in;
            pend_vld <= 1'b1;
         end
      end
   end

   assign div_ack = ack_q;
   assign div_err = err_q;
   assign div_cur = div_q;
   assign wrap    = enable && at_wrap;

`ifdef DIV_PROG_ODD_DUTY50_EN
   logic neg_q;
   logic run_q;

   // Half-cycle stretch of the high phase; qualified by N[0] so even ratios
   // never see it. run_q kills the stretch on the same edge that stops us.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) neg_q <= 1'b0;
      else        neg_q <= pos_q && div_q[0] && enable;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= enable;
   end

   assign clk_out = pos_q | (neg_q & run_q);
`else
   assign clk_out = pos_q;
`endif

endmodule
